// File: rtl/rv32imc_types.sv
// Shared RV32IMC type package: M-extension divide opcodes and the
// helpers that classify them and produce divide-by-zero/overflow results.
package rv32imc_types;

   typedef enum logic [1:0] {
      div_div  = 2'd0,
      div_divu = 2'd1,
      div_rem  = 2'd2,
      div_remu = 2'd3
   } div_op_t;

   function automatic logic op_is_signed(div_op_t op);
      return (op == div_div) || (op == div_rem);
   endfunction

   function automatic logic op_is_rem(div_op_t op);
      return (op == div_rem) || (op == div_remu);
   endfunction

   // RISC-V mandated results: x/0 gives all ones and remainder x;
   // MIN/-1 gives MIN and remainder 0.
   function automatic logic [31:0] special_result(div_op_t op, logic div0, logic [31:0] a);
      if (div0) return op_is_rem(op) ? a : 32'hFFFF_FFFF;
      return op_is_rem(op) ? 32'h0000_0000 : 32'h8000_0000;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Valid/ready request and response channels between execute and div_unit.
interface div_unit_if;
   import rv32imc_types::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   div_op_t     div_op;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;

   modport master (
      output in_valid, a, b, div_op, flush, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, a, b, div_op, flush, out_ready,
      output in_ready, out_valid, out_result
   );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, 34-cycle latency.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow on the accept edge.
module div_unit
   import rv32imc_types::*;
(
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

   state_t      state;
   div_op_t     op_q;
   logic        sign_a;
   logic        sign_b;
   logic        div0;
   logic        ovf;
   logic [31:0] a_q;
   logic [31:0] mag_b;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [4:0]  cnt;
   logic [31:0] result;
   logic        valid;

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = valid;
   assign bus.out_result = result;

   logic        accept;
   logic        in_signed;
   logic        in_neg_a;
   logic        in_neg_b;
   logic [31:0] in_mag_a;
   logic [31:0] in_mag_b;
   logic        in_div0;
   logic        in_ovf;

   always_comb begin
      accept    = bus.in_valid && (state == IDLE) && !bus.flush;
      in_signed = op_is_signed(bus.div_op);
      in_neg_a  = in_signed && bus.a[31];
      in_neg_b  = in_signed && bus.b[31];
      in_mag_a  = in_neg_a ? -bus.a : bus.a;
      in_mag_b  = in_neg_b ? -bus.b : bus.b;
      in_div0   = (bus.b == 32'd0);
      in_ovf    = in_signed && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
   end

   // The shifted remainder needs 33 bits for the compare; after the
   // restore it is always below |b| and fits back in 32.
   logic [32:0] rem_sh;
   logic [31:0] rem_sub;
   logic        take;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [31:0] fix_result;

   always_comb begin
      rem_sh     = {rem, quo[31]};
      rem_sub    = rem_sh[31:0] - mag_b;
      take       = (rem_sh >= {1'b0, mag_b});
      q_fix      = (sign_a ^ sign_b) ? -quo : quo;
      r_fix      = sign_a ? -rem : rem;
      fix_result = op_is_rem(op_q) ? r_fix : q_fix;
      if (div0 || ovf) fix_result = special_result(op_q, div0, a_q);
   end

   // NOTE: all state uses non-blocking assignments so every register
   // samples the pre-edge values; flush outranks any state transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= div_div;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         div0   <= 1'b0;
         ovf    <= 1'b0;
         a_q    <= '0;
         mag_b  <= '0;
         quo    <= '0;
         rem    <= '0;
         cnt    <= '0;
         result <= '0;
         valid  <= 1'b0;
      end else if (bus.flush) begin
         state <= IDLE;
         valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= bus.div_op;
                  sign_a <= in_neg_a;
                  sign_b <= in_neg_b;
                  div0   <= in_div0;
                  ovf    <= in_ovf;
                  a_q    <= bus.a;
                  mag_b  <= in_mag_b;
                  quo    <= in_mag_a;
                  rem    <= '0;
                  cnt    <= '0;
`ifdef DIV_EARLY_OUT_EN
                  if (in_div0 || in_ovf) begin
                     result <= special_result(bus.div_op, in_div0, bus.a);
                     valid  <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state <= BUSY;
                  end
`else
                  state <= BUSY;
`endif
               end
            end
            BUSY: begin
               rem <= take ? rem_sub : rem_sh[31:0];
               quo <= {quo[30:0], take};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= FIXUP;
            end
            FIXUP: begin
               result <= fix_result;
               valid  <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic vectors, special
// cases, latency, backpressure, flush and mid-operation reset.
module tb_div_unit;
   import rv32imc_types::*;

`ifdef DIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = 34;
`endif
   localparam int NORMAL_LAT = 34;
   localparam int MAX_WAIT   = 60;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   div_unit_if bus();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.div_op   = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Called just after the accept edge, i.e. in cycle 1.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < MAX_WAIT) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
      check({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
   endtask

   task automatic run(input string tag, input div_op_t op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      check({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
      issue(op, a, b);
      wait_valid(lat);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, bus.out_result, exp);
      check({tag, " in_ready while done"}, 32'(bus.in_ready), 32'd0);
      handshake(tag);
   endtask

   initial begin
      int lat;
      int seen;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.div_op    = div_div;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      #1;
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset out_result", bus.out_result, 32'd0);
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic arithmetic
      run("divu 100/7",   div_divu, 32'd100,       32'd7,          32'h0000_000E, NORMAL_LAT);
      run("remu 100/7",   div_remu, 32'd100,       32'd7,          32'h0000_0002, NORMAL_LAT);
      run("div -7/2",     div_div,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, NORMAL_LAT);
      run("rem -7/2",     div_rem,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, NORMAL_LAT);
      run("div -100/-7",  div_div,  32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'h0000_000E, NORMAL_LAT);
      run("rem -100/-7",  div_rem,  32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'hFFFF_FFFE, NORMAL_LAT);
      run("rem 7/-2",     div_rem,  32'd7,         32'hFFFF_FFFE,  32'h0000_0001, NORMAL_LAT);
      run("divu max/1",   div_divu, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, NORMAL_LAT);
      run("divu min/max", div_divu, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, NORMAL_LAT);

      // Special cases
      run("div 5/0",      div_div,  32'd5,         32'd0,          32'hFFFF_FFFF, SPECIAL_LAT);
      run("remu 5/0",     div_remu, 32'd5,         32'd0,          32'h0000_0005, SPECIAL_LAT);
      run("rem min/0",    div_rem,  32'h8000_0000, 32'd0,          32'h8000_0000, SPECIAL_LAT);
      run("div ovf",      div_div,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, SPECIAL_LAT);
      run("rem ovf",      div_rem,  32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, SPECIAL_LAT);

      // Backpressure: result held, no new accept while DONE
      issue(div_divu, 32'd100, 32'd7);
      wait_valid(lat);
      check("bp latency", 32'(lat), 32'(NORMAL_LAT));
      bus.div_op   = div_div;
      bus.a        = 32'd5;
      bus.b        = 32'd0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp result stable", bus.out_result, 32'h0000_000E);
         check("bp out_valid held", 32'(bus.out_valid), 32'd1);
         check("bp in_ready low", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      handshake("bp");
      repeat (3) @(posedge clk);
      #1;
      check("bp no stray accept", 32'(bus.out_valid), 32'd0);
      check("bp idle", 32'(bus.in_ready), 32'd1);

      // Flush at cycle 10, with a competing in_valid
      issue(div_divu, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      check("flush busy", 32'(bus.in_ready), 32'd0);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.div_op   = div_divu;
      bus.a        = 32'd9;
      bus.b        = 32'd0;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush in_ready", 32'(bus.in_ready), 32'd1);
      check("flush out_valid", 32'(bus.out_valid), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid || !bus.in_ready) seen++;
      end
      check("flush no output", 32'(seen), 32'd0);

      // Reset pulsed at cycle 20
      issue(div_div, 32'hFFFF_FFF9, 32'd2);
      repeat (19) @(posedge clk);
      #1;
      check("rst busy", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check("rst no output", 32'(seen), 32'd0);

      run("divu after rst", div_divu, 32'd100, 32'd7, 32'h0000_000E, NORMAL_LAT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
